mmio_bus: RTL and testbench



---
 rtl/mmio_bus_pkg.sv | 23 ++
 rtl/mmio_bus_if.sv | 34 +++
 rtl/mmio_decode.sv | 27 ++
 rtl/mmio_bus.sv | 135 +++++++++++++
 tb/tb_mmio_bus.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_bus_pkg.sv
// Shared types and constants for the MMIO bus: FSM states, error cause codes,
// default error read data and the slave-index width helper.
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_ERR    = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_DECODE  = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } err_cause_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_bus_if.sv
// Master-side request/response, per-slave fan-out and error reporting signals
// of the MMIO bus, grouped so the bus and its agents share one bundle.
interface mmio_bus_if #(
  parameter int N_SLAVES = 4
);
  logic                    m_valid;
  logic                    m_ready;
  logic [31:0]             m_addr;
  logic [31:0]             m_wdata;
  logic [3:0]              m_wstrb;
  logic [31:0]             m_rdata;
  logic [N_SLAVES-1:0]     s_valid;
  logic [N_SLAVES-1:0]     s_ready;
  logic [31:0]             s_addr;
  logic [31:0]             s_wdata;
  logic [4*N_SLAVES-1:0]   s_wstrb;
  logic [32*N_SLAVES-1:0]  s_rdata;
  logic                    err_irq;
  logic [31:0]             err_addr;
  logic [1:0]              err_cause;

  // The bus itself is the slave of the CPU-side master and drives the slave fan-out.
  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb,
           err_irq, err_addr, err_cause
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb,
           err_irq, err_addr, err_cause
  );
endinterface

// File: rtl/mmio_decode.sv
// Address decoder: per-slave base/mask compare with lowest-index priority.
module mmio_decode
  import mmio_bus_pkg::*;
#(
  parameter int                     N_SLAVES   = 4,
  parameter logic [32*N_SLAVES-1:0] SLAVE_BASE = '0,
  parameter logic [32*N_SLAVES-1:0] SLAVE_MASK = '0,
  parameter int                     IDX_W      = idx_width(N_SLAVES)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan downwards so the last match written is the lowest index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_bus.sv
// Single-master MMIO interconnect: decodes the address, forwards the request to
// one slave, and answers decode misses and slave timeouts with an error cycle.
module mmio_bus
  import mmio_bus_pkg::*;
#(
  parameter int                     N_SLAVES   = 4,
  parameter logic [32*N_SLAVES-1:0] SLAVE_BASE = {32'h0400_0000, 32'h0300_0000,
                                                  32'h0200_0000, 32'h0000_0000},
  parameter logic [32*N_SLAVES-1:0] SLAVE_MASK = {32'hFF00_0000, 32'hFF00_0000,
                                                  32'hFF00_0000, 32'hFFFF_C000},
  parameter int                     TIMEOUT    = 255,
  parameter logic [31:0]            ERR_RDATA  = DEFAULT_ERR_RDATA
) (
  input  logic      clk,
  input  logic      resetn,
  mmio_bus_if.slave bus
);

  localparam int IDX_W = idx_width(N_SLAVES);

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, hit_idx;
  logic                  hit;
  logic [15:0]           timer, timer_nxt;
  logic [16:0]           timer_inc;
  logic                  raise_err;
  err_cause_t            cause_nxt, err_cause;
  logic [31:0]           err_addr;
  logic                  sel_ready;
  logic [N_SLAVES-1:0]   s_valid;
  logic [4*N_SLAVES-1:0] s_wstrb;
  logic                  m_ready;
  logic [31:0]           m_rdata;
  logic                  err_irq;

  mmio_decode #(
    .N_SLAVES   (N_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr (bus.m_addr),
    .hit  (hit),
    .idx  (hit_idx)
  );

  assign sel_ready = bus.s_ready[idx];
  assign timer_inc = {1'b0, timer} + 17'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      timer     <= '0;
      err_addr  <= '0;
      err_cause <= CAUSE_NONE;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (state == ST_IDLE && bus.m_valid && hit) idx <= hit_idx;
      // Error registers already hold the new record during the error cycle.
      if (raise_err) begin
        err_addr  <= bus.m_addr;
        err_cause <= cause_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    raise_err = 1'b0;
    cause_nxt = CAUSE_NONE;
    case (state)
      ST_IDLE: begin
        if (bus.m_valid) begin
          if (hit) begin
            state_nxt = ST_ACTIVE;
            timer_nxt = '0;
          end else begin
            state_nxt = ST_ERR;
            raise_err = 1'b1;
            cause_nxt = CAUSE_DECODE;
          end
        end
      end
      ST_ACTIVE: begin
        // A slave answer in the timeout cycle still counts as a normal completion.
        if (sel_ready || !bus.m_valid) begin
          state_nxt = ST_IDLE;
        end else if (timer_inc == 17'(TIMEOUT)) begin
          state_nxt = ST_ERR;
          raise_err = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          timer_nxt = timer_inc[15:0];
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_valid = '0;
    s_wstrb = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    err_irq = 1'b0;
    case (state)
      ST_ACTIVE: begin
        s_valid[idx]               = bus.m_valid;
        s_wstrb[int'(idx)*4 +: 4]  = bus.m_wstrb;
        m_ready                    = sel_ready;
        if (sel_ready) m_rdata     = bus.s_rdata[int'(idx)*32 +: 32];
      end
      ST_ERR: begin
        m_ready = 1'b1;
        m_rdata = ERR_RDATA;
        err_irq = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.s_valid   = s_valid;
  assign bus.s_wstrb   = s_wstrb;
  assign bus.s_addr    = bus.m_addr;
  assign bus.s_wdata   = bus.m_wdata;
  assign bus.m_ready   = m_ready;
  assign bus.m_rdata   = m_rdata;
  assign bus.err_irq   = err_irq;
  assign bus.err_addr  = err_addr;
  assign bus.err_cause = err_cause;

endmodule

// File: tb/tb_mmio_bus.sv
// Self-checking bench for mmio_bus: directed scenarios plus randomized
// transactions compared against a transaction-level model of the address map.
module tb_mmio_bus;

  localparam int TO = 4;
  localparam logic [127:0] BASE = {32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0000_0000};
  localparam logic [127:0] MASK = {32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_C000};
  // Second instance: slave 1 matches every address, slave 0 only the low 64 KiB.
  localparam logic [63:0]  OV_BASE = {32'h0000_0000, 32'h0000_0000};
  localparam logic [63:0]  OV_MASK = {32'h0000_0000, 32'hFFFF_0000};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mmio_bus_if #(.N_SLAVES(4)) bus ();
  mmio_bus_if #(.N_SLAVES(2)) bus_ov ();

  mmio_bus #(
    .N_SLAVES(4), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (.clk(clk), .resetn(resetn), .bus(bus));

  mmio_bus #(
    .N_SLAVES(2), .SLAVE_BASE(OV_BASE), .SLAVE_MASK(OV_MASK)
  ) dut_ov (.clk(clk), .resetn(resetn), .bus(bus_ov));

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_err_addr  = '0;
  logic [1:0]  exp_err_cause = '0;

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return i;
    return -1;
  endfunction

  task automatic drive_slaves(input int sel, input logic rdy, input logic [31:0] data);
    for (int i = 0; i < 4; i++) begin
      bus.s_ready[i]         = (i == sel) ? rdy : 1'($urandom_range(0, 1));
      bus.s_rdata[i*32 +: 32] = (i == sel) ? data : $urandom;
    end
  endtask

  // One complete transaction, entered just after a rising edge.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int lat,
                         input logic [31:0] data, input string name);
    int sel;
    int act_cycles;
    bit to_err;
    logic [1:0]  cause;
    logic [3:0]  exp_sv;
    logic [15:0] exp_sw;
    logic        exp_mr;
    logic [31:0] exp_rd;
    sel = model_sel(addr);
    cause = 2'b00;
    if (sel < 0) begin
      act_cycles = 0; to_err = 1'b1; cause = 2'b01;
    end else if (lat < TO) begin
      act_cycles = lat + 1; to_err = 1'b0;
    end else begin
      act_cycles = TO; to_err = 1'b1; cause = 2'b10;
    end
    bus.m_valid = 1'b1; bus.m_addr = addr; bus.m_wdata = wdata; bus.m_wstrb = wstrb;
    drive_slaves(sel, 1'b0, data);
    @(negedge clk);
    checks++;
    if ({bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq} !== 54'd0) begin
      errors++;
      $display("FAIL %s decode: got rdy=%b rd=%h sv=%b sw=%h irq=%b want all 0", name,
               bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq);
    end
    for (int k = 0; k < act_cycles; k++) begin
      @(posedge clk); #1;
      drive_slaves(sel, (k == lat), data);
      @(negedge clk);
      exp_sv = 4'b0001 << sel;
      exp_sw = 16'(wstrb) << (4 * sel);
      exp_mr = (k == lat);
      exp_rd = exp_mr ? data : 32'h0;
      checks++;
      if ({bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq, bus.s_addr, bus.s_wdata}
          !== {exp_mr, exp_rd, exp_sv, exp_sw, 1'b0, addr, wdata}) begin
        errors++;
        $display("FAIL %s active%0d: got rdy=%b rd=%h sv=%b sw=%h irq=%b sa=%h sd=%h want rdy=%b rd=%h sv=%b sw=%h irq=0 sa=%h sd=%h",
                 name, k, bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq,
                 bus.s_addr, bus.s_wdata, exp_mr, exp_rd, exp_sv, exp_sw, addr, wdata);
      end
    end
    if (to_err) begin
      @(posedge clk); #1;
      drive_slaves(-1, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq}
          !== {1'b1, 32'hDEAD_BEEF, 4'b0, 16'b0, 1'b1}) begin
        errors++;
        $display("FAIL %s errcycle: got rdy=%b rd=%h sv=%b sw=%h irq=%b want rdy=1 rd=deadbeef sv=0 sw=0 irq=1",
                 name, bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq);
      end
      exp_err_addr = addr;
      exp_err_cause = cause;
      @(posedge clk); #1;
      bus.m_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({bus.err_addr, bus.err_cause} !== {exp_err_addr, exp_err_cause}) begin
      errors++;
      $display("FAIL %s errregs: got addr=%h cause=%b want addr=%h cause=%b", name,
               bus.err_addr, bus.err_cause, exp_err_addr, exp_err_cause);
    end
    @(posedge clk); #1;
    bus.m_valid = 1'b0; bus.m_wstrb = 4'b0; bus.s_ready = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.m_valid = 1'b1; bus.m_addr = 32'h0200_0000; bus.m_wdata = $urandom; bus.m_wstrb = 4'hF;
    drive_slaves(1, 1'b1, 32'h5555_AAAA);
    bus_ov.m_valid = 1'b0; bus_ov.m_addr = '0; bus_ov.m_wdata = '0; bus_ov.m_wstrb = '0;
    bus_ov.s_ready = '0; bus_ov.s_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (|{bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq, bus.err_addr, bus.err_cause} !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b rd=%h sv=%b sw=%h irq=%b ea=%h ec=%b want all 0",
               bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq, bus.err_addr, bus.err_cause);
    end
    bus.m_valid = 1'b0; bus.m_wstrb = 4'b0; bus.s_ready = '0;
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_directed();
    // Slave 0 sits in the LSBs of the base vector, so 0x0200_0000 is slave 1.
    run_txn(32'h0200_0004, 32'h0, 4'b0000, 3, 32'h1234_5678, "read_s1");
    idle(1);
    run_txn(32'h0300_0004, 32'h0, 4'b0000, 2, 32'h0BAD_F00D, "read_s2");
    idle(1);
    run_txn(32'h0000_1000, 32'hCAFE_0001, 4'b0011, 0, 32'h0, "write_s0");
    idle(1);
    run_txn(32'h0700_0000, 32'h0, 4'b0000, 0, 32'h0, "miss_read");
    idle(1);
    run_txn(32'h0000_4000, 32'hFFFF_FFFF, 4'b1111, 0, 32'h0, "miss_write");
    idle(1);
  endtask

  task automatic test_timeout();
    run_txn(32'h0400_0010, 32'h0, 4'b0000, 1000, 32'h0, "timeout_s3");
    idle(1);
    run_txn(32'h0400_0020, 32'h0, 4'b0000, TO - 1, 32'h7777_0003, "ready_at_limit");
    idle(1);
    run_txn(32'h0400_0030, 32'h1111_2222, 4'b1000, 1000, 32'h0, "timeout_write");
    idle(1);
  endtask

  task automatic test_abort();
    bus.m_valid = 1'b1; bus.m_addr = 32'h0300_0040; bus.m_wstrb = 4'b0;
    drive_slaves(2, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive_slaves(2, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.s_valid !== 4'b0100) begin
      errors++;
      $display("FAIL abort_active: got sv=%b want 0100", bus.s_valid);
    end
    @(posedge clk); #1;
    bus.m_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.m_ready, bus.s_valid, bus.err_irq, bus.err_cause} !== {1'b0, 4'b0, 1'b0, exp_err_cause}) begin
        errors++;
        $display("FAIL abort%0d: got rdy=%b sv=%b irq=%b ec=%b want rdy=0 sv=0 irq=0 ec=%b",
                 c, bus.m_ready, bus.s_valid, bus.err_irq, bus.err_cause, exp_err_cause);
      end
      @(posedge clk); #1;
    end
    run_txn(32'h0300_0044, 32'h0, 4'b0000, 1, 32'hA5A5_0001, "after_abort");
  endtask

  task automatic test_back_to_back();
    run_txn(32'h0000_0010, 32'h0101_0101, 4'b0001, 0, 32'h0, "b2b_0");
    run_txn(32'h0300_0100, 32'h0, 4'b0000, 1, 32'h2222_3333, "b2b_1");
    run_txn(32'h0200_0200, 32'h0, 4'b0000, 0, 32'h4444_5555, "b2b_2");
    idle(1);
  endtask

  task automatic test_reset_mid();
    bus.m_valid = 1'b1; bus.m_addr = 32'h0300_0008; bus.m_wstrb = 4'b0;
    drive_slaves(2, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.s_valid !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_active: got sv=%b want 0100", bus.s_valid);
    end
    #1 resetn = 1'b0;
    drive_slaves(2, 1'b1, 32'h9999_0000);
    #1;
    checks++;
    if (|{bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq, bus.err_addr, bus.err_cause} !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got rdy=%b rd=%h sv=%b sw=%h irq=%b ea=%h ec=%b want all 0",
               bus.m_ready, bus.m_rdata, bus.s_valid, bus.s_wstrb, bus.err_irq, bus.err_addr, bus.err_cause);
    end
    bus.m_valid = 1'b0; bus.s_ready = '0;
    exp_err_addr = '0; exp_err_cause = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.m_ready, bus.s_valid} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_release: got rdy=%b sv=%b want 0", bus.m_ready, bus.s_valid);
    end
    @(posedge clk); #1;
    run_txn(32'h0300_0008, 32'h0, 4'b0000, 2, 32'h3C3C_3C3C, "after_reset");
  endtask

  task automatic test_overlap();
    int n_sv;
    bit done;
    bus_ov.m_valid = 1'b1; bus_ov.m_addr = 32'h0000_0000;
    @(posedge clk); #1;
    bus_ov.s_ready = 2'b11;
    bus_ov.s_rdata = {32'hBBBB_0001, 32'hAAAA_0000};
    @(negedge clk);
    checks++;
    if ({bus_ov.s_valid, bus_ov.m_ready, bus_ov.m_rdata} !== {2'b01, 1'b1, 32'hAAAA_0000}) begin
      errors++;
      $display("FAIL overlap: got sv=%b rdy=%b rd=%h want sv=01 rdy=1 rd=aaaa0000",
               bus_ov.s_valid, bus_ov.m_ready, bus_ov.m_rdata);
    end
    @(posedge clk); #1;
    bus_ov.m_valid = 1'b0; bus_ov.s_ready = '0;
    @(posedge clk); #1;
    // Slave 1 never answers: the default 255-cycle timeout must fire.
    bus_ov.m_valid = 1'b1; bus_ov.m_addr = 32'h1234_0000;
    n_sv = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus_ov.s_valid[1]) n_sv++;
      if (bus_ov.m_ready) begin
        done = 1'b1;
        checks++;
        if ({n_sv, bus_ov.m_rdata, bus_ov.err_irq} !== {32'd255, 32'hDEAD_BEEF, 1'b1}) begin
          errors++;
          $display("FAIL default_timeout: got svcycles=%0d rd=%h irq=%b want svcycles=255 rd=deadbeef irq=1",
                   n_sv, bus_ov.m_rdata, bus_ov.err_irq);
        end
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL default_timeout: got no m_ready within 300 cycles want one after 255");
    end
    @(posedge clk); #1;
    bus_ov.m_valid = 1'b0;
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 5);
      case (r)
        0:       a = {18'h0, 14'($urandom)};
        1, 2, 3: a = {8'(r + 1), 24'($urandom)};
        4:       a = {8'($urandom_range(5, 255)), 24'($urandom)};
        default: a = 32'h0001_0000 | ($urandom & 32'h0000_FFFF);
      endcase
      run_txn(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0,
              $urandom_range(0, 6), $urandom, "random");
      if ($urandom_range(0, 1) != 0) idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_overlap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
